// File: rtl/seq_detect_1011.sv
// seq_detect_1011
//   Moore serial pattern detector for the bit sequence 1-0-1-1, overlaps
//   included. It consumes the dout stream of the upstream Moore stage and
//   counts detections in a saturating counter.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   din         : serial data bit, sampled only when din_valid = 1
//   din_valid   : qualifies din
//   cnt_clr     : synchronous clear of match_count (state is unaffected)
//   match       : 1 while the state is S4 (pure decode of the state register)
//   state       : current state encoding (S0..S4 = 0..4)
//   match_count : number of detections, saturates at all-ones
module seq_detect_1011 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             match,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [2:0] {
        S0 = 3'd0,   // no prefix
        S1 = 3'd1,   // "1"
        S2 = 3'd2,   // "10"
        S3 = 3'd3,   // "101"
        S4 = 3'd4    // "1011" detected
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hit;     // S3 -> S4 on this edge

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        case (state_q)
            S0: if (din_valid) state_d = din ? S1 : S0;
            S1: if (din_valid) state_d = din ? S1 : S2;
            S2: if (din_valid) state_d = din ? S3 : S0;
            S3: begin
                if (din_valid) begin
                    if (din) begin
                        state_d = S4;
                        hit     = 1'b1;
                    end else begin
                        state_d = S2;
                    end
                end
            end
            // Overlap: trailing "1" restarts at S1, trailing "10" lands in S2.
            S4: if (din_valid) state_d = din ? S1 : S2;
            // Codes 5-7 recover unconditionally.
            default: state_d = S0;
        endcase
    end

    // Counting on the S3->S4 transition rather than on state==S4 keeps
    // a hold in S4 (din_valid low) from being counted more than once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + CNT_ONE;
        end
    end

    assign state = state_q;
    assign match = (state_q == S4);

endmodule
